// File: rtl/des_buf_pkg.sv
// Shared constants and types for the 3DES output buffering path.
package des_buf_pkg;

  localparam int DES_BLK_W = 64;
  localparam int BUS_W     = 32;

  typedef logic [BUS_W-1:0] bus_word_t;

  // Number of read-side words carried by one write-side block.
  function automatic int ratio(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

endpackage

// File: rtl/wrap_ptr.sv
// Wrapping pointer register: advances by STEP when enabled, returns to zero on clr.
module wrap_ptr #(
  parameter int PTR_W = 5,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             en,
  input  logic             clr,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] ptr_d, ptr_q;

  // Storage depth is a power of two, so natural PTR_W overflow is the mod-DEPTH wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (clr)     ptr_d = '0;
    else if (en) ptr_d = ptr_q + PTR_W'(STEP);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/out_width_fifo.sv
// Width-converting circular FIFO: accepts IN_W-bit cipher blocks, emits OUT_W-bit words (FWFT).
module out_width_fifo
  import des_buf_pkg::*;
#(
  parameter  int IN_W      = DES_BLK_W,
  parameter  int OUT_W     = BUS_W,
  parameter  int DEPTH     = 32,
  parameter  int AFULL_LVL = 24,
  parameter  int LSW_FIRST = 1,
  localparam int RATIO     = ratio(IN_W, OUT_W),
  localparam int LVL_W     = $clog2(DEPTH + 1),
  localparam int PTR_W     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LVL_W-1:0] level,
  output logic             afull,
  output logic             ovf_err
);

  if (IN_W % OUT_W != 0) begin : g_chk_ratio
    $error("IN_W must be an integer multiple of OUT_W");
  end
  if ((DEPTH & (DEPTH - 1)) != 0) begin : g_chk_pow2
    $error("DEPTH must be a power of two");
  end
  if (DEPTH < 2 * RATIO) begin : g_chk_depth
    $error("DEPTH must hold at least two blocks");
  end
  if (AFULL_LVL > DEPTH) begin : g_chk_afull
    $error("AFULL_LVL must not exceed DEPTH");
  end

  localparam logic [LVL_W-1:0] RDY_MAX = LVL_W'(DEPTH - RATIO);
  localparam logic [LVL_W-1:0] AFULL_V = LVL_W'(AFULL_LVL);
  localparam logic [LVL_W-1:0] BLK_V   = LVL_W'(RATIO);

  logic [OUT_W-1:0] mem_d [DEPTH];
  logic [OUT_W-1:0] mem_q [DEPTH];
  logic [LVL_W-1:0] level_d, level_q;
  logic             ovf_d, ovf_q;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop;

  // Flags come from registered level only, so no ready/valid path is combinational through the FIFO.
  assign in_ready  = (level_q <= RDY_MAX);
  assign out_valid = (level_q != '0);
  assign afull     = (level_q >= AFULL_V);
  assign push      = in_valid & in_ready & ~clear;
  assign pop       = out_valid & out_ready & ~clear;

  wrap_ptr #(.PTR_W(PTR_W), .STEP(RATIO)) u_wr_ptr (
    .clk   (clk),
    .n_rst (n_rst),
    .en    (push),
    .clr   (clear),
    .ptr   (wr_ptr)
  );

  wrap_ptr #(.PTR_W(PTR_W), .STEP(1)) u_rd_ptr (
    .clk   (clk),
    .n_rst (n_rst),
    .en    (pop),
    .clr   (clear),
    .ptr   (rd_ptr)
  );

  // NOTE: every always_comb output gets a default first, otherwise untouched paths infer latches.
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      for (int k = 0; k < RATIO; k++) begin
        if (LSW_FIRST != 0) mem_d[wr_ptr + PTR_W'(k)] = in_data[k*OUT_W +: OUT_W];
        else                mem_d[wr_ptr + PTR_W'(k)] = in_data[(RATIO-1-k)*OUT_W +: OUT_W];
      end
    end
  end

  always_comb begin
    level_d = level_q;
    ovf_d   = ovf_q | (in_valid & ~in_ready);
    if (clear) begin
      level_d = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10:   level_d = level_q + BLK_V;
        2'b01:   level_d = level_q - 1'b1;
        2'b11:   level_d = level_q + BLK_V - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  // NOTE: storage is zeroed on reset so out_data reads 0 after reset; clear leaves it alone.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_data = mem_q[rd_ptr];
  assign level    = level_q;
  assign ovf_err  = ovf_q;

  assert property (@(posedge clk) disable iff (!n_rst) level_q <= LVL_W'(DEPTH));

endmodule

// File: tb/tb_out_width_fifo.sv
// Directed bench for out_width_fifo with a word scoreboard and a bench-side level/flag model.
module tb_out_width_fifo;

  localparam int IN_W  = 64;
  localparam int OUT_W = 32;
  localparam int DEPTH = 32;
  localparam int AFULL = 24;
  localparam int RATIO = IN_W / OUT_W;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             n_rst = 1'b1;
  logic             clear = 1'b0;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [LVL_W-1:0] level;
  logic             afull;
  logic             ovf_err;

  int errors = 0;
  int checks = 0;
  int mdl_level = 0;
  bit mdl_ovf = 1'b0;
  logic [OUT_W-1:0] sb_q [$];

  out_width_fifo #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .AFULL_LVL(AFULL), .LSW_FIRST(1)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .afull     (afull),
    .ovf_err   (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_level"},     64'(level),     64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready"},  64'(in_ready),  64'd1);
    check({tag, "_out_data"},  64'(out_data),  64'd0);
    check({tag, "_afull"},     64'(afull),     64'd0);
    check({tag, "_ovf_err"},   64'(ovf_err),   64'd0);
  endtask

  // One clock: compare flags at the negedge, update the model/scoreboard, step past the posedge.
  task automatic cycle();
    bit m_rdy, m_val, push, pop;
    logic [OUT_W-1:0] exp_w;
    @(negedge clk);
    m_rdy = (mdl_level <= DEPTH - RATIO);
    m_val = (mdl_level != 0);
    check("level",     64'(level),     64'(mdl_level));
    check("in_ready",  64'(in_ready),  64'(m_rdy));
    check("out_valid", 64'(out_valid), 64'(m_val));
    check("afull",     64'(afull),     64'(mdl_level >= AFULL));
    check("ovf_err",   64'(ovf_err),   64'(mdl_ovf));
    push = in_valid && m_rdy;
    pop  = m_val && out_ready;
    if (clear) begin
      sb_q.delete();
      mdl_level = 0;
      mdl_ovf   = 1'b0;
    end else begin
      if (pop) begin
        exp_w = sb_q.pop_front();
        check("out_data", 64'(out_data), 64'(exp_w));
      end
      if (push)
        for (int k = 0; k < RATIO; k++) sb_q.push_back(in_data[k*OUT_W +: OUT_W]);
      if (in_valid && !m_rdy) mdl_ovf = 1'b1;
      mdl_level = mdl_level + (push ? RATIO : 0) - (pop ? 1 : 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_blk(input logic [IN_W-1:0] d, input bit rd);
    in_data = d; in_valid = 1'b1; out_ready = rd;
    cycle();
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 2 * DEPTH && mdl_level != 0; n++) cycle();
    out_ready = 1'b0;
    cycle();
  endtask

  initial begin
    // T1: reset and idle
    #1 n_rst = 1'b0;
    #1 check_reset_outs("t1_rst");
    @(posedge clk); #1;
    n_rst = 1'b1;
    cycle();

    // T2: word order with LSW first
    push_blk(64'hAAAA_BBBB_1111_2222, 1'b1);
    @(negedge clk);
    check("t2_first_word", 64'(out_data), 64'h1111_2222);
    @(posedge clk); #1;
    out_ready = 1'b1;
    cycle();
    cycle();
    cycle();
    out_ready = 1'b0;

    // T3: fill to full, then overflow attempt
    for (int i = 0; i < DEPTH / RATIO; i++) push_blk({32'(i) ^ 32'h5A5A_0000, 32'(i) + 32'h100}, 1'b0);
    push_blk(64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
    @(negedge clk);
    check("t3_full_level", 64'(level), 64'(DEPTH));
    check("t3_ovf",        64'(ovf_err), 64'd1);
    check("t3_head",       64'(out_data), 64'h0000_0100);
    @(posedge clk); #1;
    drain();

    // T4: level 5, simultaneous push/pop, then several pointer wraps
    push_blk(64'h0000_0001_0000_0000, 1'b0);
    push_blk(64'h0000_0003_0000_0002, 1'b0);
    push_blk(64'h0000_0005_0000_0004, 1'b0);
    out_ready = 1'b1; cycle(); out_ready = 1'b0;
    push_blk(64'h0000_0007_0000_0006, 1'b1);
    @(negedge clk);
    check("t4_level6", 64'(level), 64'd6);
    @(posedge clk); #1;
    for (int i = 0; i < 150; i++) begin
      in_data   = {$urandom(), $urandom()};
      in_valid  = (i % 3 != 0);
      out_ready = 1'b1;
      cycle();
    end
    drain();

    // T5: clear at level 9 with push and pop requested
    for (int i = 0; i < 5; i++) push_blk({$urandom(), $urandom()}, 1'b0);
    out_ready = 1'b1; cycle();
    in_valid = 1'b1; clear = 1'b1; in_data = {$urandom(), $urandom()};
    @(negedge clk);
    check("t5_level9", 64'(level), 64'd9);
    @(posedge clk); #1;
    sb_q.delete(); mdl_level = 0; mdl_ovf = 1'b0;
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    cycle();

    // T6: asynchronous reset between edges at level 7
    for (int i = 0; i < 4; i++) push_blk({$urandom(), $urandom()}, 1'b0);
    out_ready = 1'b1; cycle(); out_ready = 1'b0;
    @(negedge clk);
    check("t6_level7", 64'(level), 64'd7);
    #2 n_rst = 1'b0;
    #1 check_reset_outs("t6_rst");
    sb_q.delete(); mdl_level = 0; mdl_ovf = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    cycle();
    push_blk(64'h1234_5678_9ABC_DEF0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
